// File: rtl/jacobi_residual.sv
// jacobi_residual: sequential residual checker for the fixed-point Jacobi solver.
// Snapshots A, b and x on start, then uses one multiply-accumulate per clock to
// form r = b - A*x row by row. It then reports max|r| and a converged flag
// (max|r| <= TOLERANCE).
// Optional build macro: JACOBI_RESIDUAL_SAT_EN
//   defined   -> each r[i] saturates to the signed W-bit range
//   undefined -> each r[i] keeps the low W bits of the difference (wrap)
module jacobi_residual #(
  parameter int          SIZE      = 3,
  parameter int          PRECISION = 16,
  parameter int          POINT     = 7,
  parameter int unsigned TOLERANCE = 1 << POINT
) (
  input  logic                                clk,
  input  logic                                I_RST,
  input  logic                                start,
  input  logic signed [PRECISION+POINT-1:0]   A [SIZE][SIZE],
  input  logic signed [PRECISION+POINT-1:0]   b [SIZE],
  input  logic signed [PRECISION+POINT-1:0]   x [SIZE],
  output logic signed [PRECISION+POINT-1:0]   r [SIZE],
  output logic        [PRECISION+POINT-1:0]   max_abs_r,
  output logic                                converged,
  output logic                                ready
);

  localparam int W      = PRECISION + POINT;
  localparam int IDX_W  = $clog2(SIZE);
  // Sized to hold a full sum of SIZE shifted 2W-bit products, so it never overflows.
  localparam int ACC_W  = 2 * W - POINT + $clog2(SIZE) + 1;
  localparam int DIFF_W = ACC_W + 1;

  localparam logic [W-1:0]       TOL_W   = W'(TOLERANCE);
  localparam logic [W-1:0]       ABS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [IDX_W-1:0]   LAST    = IDX_W'(SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_FINISH, S_DONE} state_t;

  state_t                    r_state, w_state_nxt;

  logic signed [W-1:0]       r_a [SIZE][SIZE];
  logic signed [W-1:0]       r_b [SIZE];
  logic signed [W-1:0]       r_x [SIZE];
  logic        [IDX_W-1:0]   r_row, r_col;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [W-1:0]       r_res [SIZE];
  logic        [W-1:0]       r_max;
  logic                      r_conv;

  logic                      w_load, w_mac_en, w_fin_en;
  logic                      w_last_col, w_last_row;
  logic signed [2*W-1:0]     w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext, w_sum;
  logic signed [DIFF_W-1:0]  w_diff;
  logic signed [W-1:0]       w_res;
  logic        [W-1:0]       w_abs, w_max;

  assign w_last_col = (r_col == LAST);
  assign w_last_row = (r_row == LAST);

  // State register; an asynchronous reset aborts any evaluation in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: start is honoured only in IDLE and DONE.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_MAC;
      S_MAC:    if (w_last_row && w_last_col) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_DONE;
      S_DONE:   if (start) w_state_nxt = S_MAC;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output and strobe decode from the current state.
  always_comb begin
    ready    = (r_state == S_DONE);
    w_load   = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
    w_mac_en = (r_state == S_MAC);
    w_fin_en = (r_state == S_FINISH);
  end

  // Operand snapshot taken on the accepting edge; inputs are free afterwards.
  // NOTE: pure data storage with no reset; every word is loaded before it is read.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_a <= A;
      r_b <= b;
      r_x <= x;
    end
  end

  // One product per clock; the arithmetic shift keeps the sign of the product.
  assign w_prod     = r_a[r_row][r_col] * r_x[r_col];
  assign w_prod_ext = ACC_W'(w_prod >>> POINT);
  assign w_sum      = r_acc + w_prod_ext;
  assign w_diff     = DIFF_W'(r_b[r_row]) - DIFF_W'(w_sum);

`ifdef JACOBI_RESIDUAL_SAT_EN
  localparam logic signed [DIFF_W-1:0] SAT_HI = {{(DIFF_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [DIFF_W-1:0] SAT_LO = {{(DIFF_W-W+1){1'b1}}, {(W-1){1'b0}}};

  // Clamp the full-width difference into the signed W-bit range.
  always_comb begin
    if (w_diff > SAT_HI)      w_res = {1'b0, {(W-1){1'b1}}};
    else if (w_diff < SAT_LO) w_res = {1'b1, {(W-1){1'b0}}};
    else                      w_res = W'(w_diff);
  end
`else
  // Keep the low W bits of the difference (two's-complement wrap).
  always_comb begin
    w_res = W'(w_diff);
  end
`endif

  // Largest magnitude over the residual; |-2^(W-1)| is clamped to 2^(W-1)-1.
  always_comb begin
    w_max = '0;
    w_abs = '0;
    for (int i = 0; i < SIZE; i++) begin
      w_abs = r_res[i][W-1] ? (~r_res[i] + W'(1)) : r_res[i];
      if (w_abs[W-1]) w_abs = ABS_MAX;
      if (w_abs > w_max) w_max = w_abs;
    end
  end

  // Datapath: counters, accumulator, row writes and the FINISH summary.
  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      r_row  <= '0;
      r_col  <= '0;
      r_acc  <= '0;
      r_max  <= '0;
      r_conv <= 1'b0;
      for (int i = 0; i < SIZE; i++) r_res[i] <= '0;
    end else if (w_load) begin
      r_row <= '0;
      r_col <= '0;
      r_acc <= '0;
    end else if (w_mac_en) begin
      if (w_last_col) begin
        r_res[r_row] <= w_res;
        r_acc        <= '0;
        r_col        <= '0;
        r_row        <= w_last_row ? '0 : r_row + IDX_W'(1);
      end else begin
        r_acc <= w_sum;
        r_col <= r_col + IDX_W'(1);
      end
    end else if (w_fin_en) begin
      r_max  <= w_max;
      r_conv <= (w_max <= TOL_W);
    end
  end

  assign r         = r_res;
  assign max_abs_r = r_max;
  assign converged = r_conv;

endmodule

// File: tb/tb_jacobi_residual.sv
// Self-checking bench for jacobi_residual: directed cases plus randomized runs
// compared against a plain-arithmetic reference model of r = b - A*x.
module tb_jacobi_residual;

  localparam int     SIZE      = 3;
  localparam int     PRECISION = 16;
  localparam int     POINT     = 7;
  localparam int     W         = PRECISION + POINT;
  localparam longint TOL       = 128;
  localparam int     LATENCY   = SIZE * SIZE + 1;

  logic                clk = 1'b0;
  logic                I_RST;
  logic                start;
  logic signed [W-1:0] a_i [SIZE][SIZE];
  logic signed [W-1:0] b_i [SIZE];
  logic signed [W-1:0] x_i [SIZE];
  logic signed [W-1:0] r_o [SIZE];
  logic        [W-1:0] max_o;
  logic                conv_o;
  logic                ready_o;

  int n_cmp = 0;
  int n_bad = 0;

  longint ma [SIZE][SIZE];
  longint mb [SIZE];
  longint mx [SIZE];
  longint er [SIZE];
  longint emax;
  longint econv;

  longint              wrap_v;
  logic signed [W-1:0] wrap_r;
  int                  cyc;

  jacobi_residual #(
    .SIZE(SIZE), .PRECISION(PRECISION), .POINT(POINT), .TOLERANCE(128)
  ) dut (
    .clk(clk), .I_RST(I_RST), .start(start),
    .A(a_i), .b(b_i), .x(x_i),
    .r(r_o), .max_abs_r(max_o), .converged(conv_o), .ready(ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: r[i] = b[i] - sum_j ((A[i][j]*x[j]) >>> POINT), then narrowed.
  function automatic void run_model();
    longint half;
    longint acc;
    longint diff;
    longint mag;
    half = longint'(1) <<< (W - 1);
    emax = 0;
    for (int i = 0; i < SIZE; i++) begin
      acc = 0;
      for (int j = 0; j < SIZE; j++) acc += (ma[i][j] * mx[j]) >>> POINT;
      diff = mb[i] - acc;
`ifdef JACOBI_RESIDUAL_SAT_EN
      if (diff > half - 1)  diff = half - 1;
      else if (diff < -half) diff = -half;
`else
      diff = diff & ((half <<< 1) - 1);
      if (diff >= half) diff -= (half <<< 1);
`endif
      er[i] = diff;
      mag = (diff < 0) ? -diff : diff;
      if (mag > half - 1) mag = half - 1;
      if (mag > emax) emax = mag;
    end
    econv = (emax <= TOL) ? 1 : 0;
  endfunction

  task automatic capture();
    for (int i = 0; i < SIZE; i++) begin
      mb[i] = longint'(b_i[i]);
      mx[i] = longint'(x_i[i]);
      for (int j = 0; j < SIZE; j++) ma[i][j] = longint'(a_i[i][j]);
    end
    run_model();
  endtask

  task automatic set_std_a();
    int m [SIZE][SIZE];
    m = '{'{3, -1, 0}, '{-1, 3, -1}, '{0, -1, 2}};
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) a_i[i][j] = W'(m[i][j] * 128);
  endtask

  task automatic set_vec(input int v0, input int v1, input int v2, input bit is_x);
    if (is_x) begin x_i[0] = W'(v0); x_i[1] = W'(v1); x_i[2] = W'(v2); end
    else      begin b_i[0] = W'(v0); b_i[1] = W'(v1); b_i[2] = W'(v2); end
  endtask

  task automatic clear_all();
    for (int i = 0; i < SIZE; i++) begin
      b_i[i] = '0;
      x_i[i] = '0;
      for (int j = 0; j < SIZE; j++) a_i[i][j] = '0;
    end
  endtask

  task automatic wait_ready(input string tag);
    cyc = 0;
    while (ready_o !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, LATENCY);
  endtask

  task automatic compare_results(input string tag);
    for (int i = 0; i < SIZE; i++) check($sformatf("%s_r%0d", tag, i), r_o[i], er[i]);
    check({tag, "_max"}, max_o, emax);
    check({tag, "_conv"}, conv_o, econv);
  endtask

  task automatic run_and_check(input string tag);
    capture();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_ready_low"}, ready_o, 0);
    wait_ready(tag);
    compare_results(tag);
  endtask

  initial begin
    I_RST = 1'b1;
    start = 1'b0;
    clear_all();
    @(negedge clk);
    check("rst_ready", ready_o, 0);
    check("rst_max", max_o, 0);
    check("rst_conv", conv_o, 0);
    for (int i = 0; i < SIZE; i++) check($sformatf("rst_r%0d", i), r_o[i], 0);
    I_RST = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_ready", ready_o, 0);

    // Exact solution: residual is zero and the result converges.
    set_std_a();
    set_vec(52 * 128, 0, 0, 0);
    set_vec(20 * 128, 8 * 128, 4 * 128, 1);
    run_and_check("exact");
    check("exact_conv_const", conv_o, 1);

    // Partial solution: r = (256,128,128).
    set_vec(19 * 128, 7 * 128, 3 * 128, 1);
    run_and_check("partial");
    check("partial_r0_const", r_o[0], 256);
    check("partial_r1_const", r_o[1], 128);
    check("partial_r2_const", r_o[2], 128);
    check("partial_max_const", max_o, 256);
    check("partial_conv_const", conv_o, 0);

    // Snapshot: x becomes garbage after acceptance and start stays high throughout.
    capture();
    start = 1'b1;
    @(negedge clk);
    check("snap_ready_low", ready_o, 0);
    for (int j = 0; j < SIZE; j++) x_i[j] = W'($urandom());
    wait_ready("snap");
    compare_results("snap");
    check("snap_r0_const", r_o[0], 256);
    // start is still high in DONE: the next edge restarts with the garbage x.
    capture();
    @(negedge clk);
    start = 1'b0;
    check("restart_ready_low", ready_o, 0);
    wait_ready("restart");
    compare_results("restart");

    // Asynchronous reset mid-MAC after a nonzero row has been written.
    set_std_a();
    set_vec(52 * 128, 0, 0, 0);
    set_vec(19 * 128, 7 * 128, 3 * 128, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 I_RST = 1'b1;
    #1;
    check("midrst_ready", ready_o, 0);
    check("midrst_max", max_o, 0);
    check("midrst_conv", conv_o, 0);
    for (int i = 0; i < SIZE; i++) check($sformatf("midrst_r%0d", i), r_o[i], 0);
    @(negedge clk);
    I_RST = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_idle", ready_o, 0);
    run_and_check("recover");

    // Boundary: residual of exactly -2^(W-1) clamps in max_abs_r.
    clear_all();
    set_vec(-(1 << (W - 1)), (1 << (W - 1)) - 1, 0, 0);
    run_and_check("clamp");
    check("clamp_max_const", max_o, (1 << (W - 1)) - 1);

    // Boundary: max_abs_r equal to TOLERANCE converges, one above does not.
    set_vec(128, -128, 0, 0);
    run_and_check("tol_eq");
    check("tol_eq_conv_const", conv_o, 1);
    set_vec(129, 0, 0, 0);
    run_and_check("tol_above");
    check("tol_above_conv_const", conv_o, 0);

    // Large product: saturation or wrap depending on the build.
    clear_all();
    a_i[0][0] = W'(1000 * 128);
    x_i[0]    = W'(5000 * 128);
    run_and_check("big");
`ifdef JACOBI_RESIDUAL_SAT_EN
    check("sat_r0_const", r_o[0], -4194304);
    check("sat_max_const", max_o, 4194303);
`else
    wrap_v = -(longint'(5000000) <<< 7);
    wrap_r = W'(wrap_v);
    check("wrap_r0_formula", r_o[0], wrap_r);
    check("wrap_max_formula", max_o, (wrap_r < 0) ? -longint'(wrap_r) : longint'(wrap_r));
`endif
    check("big_conv_const", conv_o, 0);

    // Randomized runs: small-range values and occasional full-range values.
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < SIZE; i++) begin
        if (k % 4 == 0) begin
          b_i[i] = W'($urandom());
          x_i[i] = W'($urandom());
          for (int j = 0; j < SIZE; j++) a_i[i][j] = W'($urandom());
        end else begin
          b_i[i] = W'(int'($urandom_range(0, 1 << 16)) - (1 << 15));
          x_i[i] = W'(int'($urandom_range(0, 1 << 20)) - (1 << 19));
          for (int j = 0; j < SIZE; j++)
            a_i[i][j] = W'(int'($urandom_range(0, 4095)) - 2048);
        end
      end
      run_and_check($sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
